// File: rtl/light_pkg.sv
// Shared definitions for the light sequencer: mode encodings, sequence index
// bounds and the index-advance helper.
package light_pkg;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'b00,
        MODE_OFF   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_AUTO  = 2'b11
    } mode_e;

    localparam int unsigned IDX_W     = 3;
    localparam logic [2:0]  IDX_FIRST = 3'd1;
    localparam logic [2:0]  IDX_LAST  = 3'd6;

    // Next colour in the sequence; wraps from the last entry back to the first.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? IDX_FIRST : IDX_W'(idx + IDX_W'(1));
    endfunction

endpackage

// File: rtl/colour_lut.sv
// Combinational colour table: sequence index -> {R,G,B}.
// Ports:
//   i_idx    sequence index (1..6 meaningful; 0 and 7 map to black)
//   o_rgb_c  colour, {R,G,B}, COLOR_W bits each
module colour_lut #(
    parameter int unsigned COLOR_W = 8
) (
    input  logic [2:0]           i_idx,
    output logic [3*COLOR_W-1:0] o_rgb_c
);

    localparam logic [COLOR_W-1:0] F = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] Z = '0;

    always_comb begin
        o_rgb_c = {Z, Z, Z};
        case (i_idx)
            3'd1:    o_rgb_c = {F, Z, Z};
            3'd2:    o_rgb_c = {F, F, Z};
            3'd3:    o_rgb_c = {Z, F, Z};
            3'd4:    o_rgb_c = {Z, F, F};
            3'd5:    o_rgb_c = {Z, Z, F};
            3'd6:    o_rgb_c = {F, Z, F};
            default: o_rgb_c = {Z, Z, Z};
        endcase
    end

endmodule

// File: rtl/light_sequencer.sv
// Colour light sequencer: fixed white/off modes, button-stepped sequence and
// timed auto-advance with a per-colour dwell counter.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   enable      permits colour advance and dwell counting
//   mode        00 WHITE, 01 OFF, 10 STEP, 11 AUTO
//   button      level input; a rising edge is the event
//   light       registered colour {R,G,B}
//   colour_idx  registered sequence index
module light_sequencer
    import light_pkg::*;
#(
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned DWELL   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic                 button,
    output logic [3*COLOR_W-1:0] light,
    output logic [2:0]           colour_idx
);

    localparam int unsigned LIGHT_W = 3 * COLOR_W;
    localparam int unsigned CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_btn_q;
    mode_e              r_mode_q;
    logic [LIGHT_W-1:0] r_light;

    mode_e              w_mode;
    logic               w_rise;
    logic [IDX_W-1:0]   w_idx_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic [LIGHT_W-1:0] w_light_n;
    logic [LIGHT_W-1:0] w_lut;

    assign w_mode = mode_e'(mode);
    assign w_rise = button & ~r_btn_q;

    colour_lut #(.COLOR_W(COLOR_W)) u_lut (
        .i_idx   (r_idx),
        .o_rgb_c (w_lut)
    );

    // Next index, dwell count and colour.
    always_comb begin
        w_idx_n   = r_idx;
        w_cnt_n   = r_cnt;
        w_light_n = '0;

        // A mode change only restarts the dwell; the index is kept.
        if (w_mode != r_mode_q) begin
            w_cnt_n = '0;
        end else begin
            case (w_mode)
                MODE_STEP: begin
                    if (w_rise && enable) begin
                        w_idx_n = next_idx(r_idx);
                    end
                end
                MODE_AUTO: begin
                    // Button restarts the dwell and beats a terminal count.
                    if (w_rise) begin
                        w_cnt_n = '0;
                    end else if (enable) begin
                        if (r_cnt == CNT_LAST) begin
                            w_idx_n = next_idx(r_idx);
                            w_cnt_n = '0;
                        end else begin
                            w_cnt_n = CNT_W'(r_cnt + CNT_W'(1));
                        end
                    end
                end
                default: ;
            endcase
        end

        case (w_mode)
            MODE_WHITE: w_light_n = '1;
            MODE_OFF:   w_light_n = '0;
            default:    w_light_n = w_lut;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx    <= IDX_FIRST;
            r_cnt    <= '0;
            r_btn_q  <= 1'b0;
            r_mode_q <= MODE_OFF;
            r_light  <= '0;
        end else begin
            r_idx    <= w_idx_n;
            r_cnt    <= w_cnt_n;
            r_btn_q  <= button;
            r_mode_q <= w_mode;
            r_light  <= w_light_n;
        end
    end

    assign light      = r_light;
    assign colour_idx = r_idx;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer (COLOR_W=8, DWELL=4): directed
// scenarios followed by random stimulus against a behavioural model.
module tb_light_sequencer;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 4;
    localparam int unsigned LW = 3 * CW;

    localparam int M_WHITE = 0;
    localparam int M_OFF   = 1;
    localparam int M_STEP  = 2;
    localparam int M_AUTO  = 3;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode   = 2'b01;
    logic          button = 1'b0;
    logic [LW-1:0] light;
    logic [2:0]    colour_idx;

    always #5 clk = ~clk;

    light_sequencer #(.COLOR_W(CW), .DWELL(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .button     (button),
        .light      (light),
        .colour_idx (colour_idx)
    );

    typedef struct packed {
        logic [LW-1:0] light;
        logic [2:0]    idx;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state.
    int m_idx  = 1;
    int m_cnt  = 0;
    bit m_btn  = 1'b0;
    int m_mode = M_OFF;

    function automatic logic [LW-1:0] tbl(input int idx);
        logic [CW-1:0] r, g, b;
        r = (idx == 1 || idx == 2 || idx == 6) ? 8'hFF : 8'h00;
        g = (idx == 2 || idx == 3 || idx == 4) ? 8'hFF : 8'h00;
        b = (idx == 4 || idx == 5 || idx == 6) ? 8'hFF : 8'h00;
        return {r, g, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // One clock of stimulus; the model predicts the outputs after the next edge.
    task automatic cyc(input bit r, input bit e, input int md, input bit b);
        exp_t x;
        bit   rise;
        @(negedge clk);
        rst    = r;
        enable = e;
        mode   = 2'(md);
        button = b;
        if (!r) begin
            m_idx = 1; m_cnt = 0; m_btn = 1'b0; m_mode = M_OFF;
            x.light = '0;
        end else begin
            rise = b && !m_btn;
            x.light = (md == M_WHITE) ? {LW{1'b1}} :
                      (md == M_OFF)   ? '0 : tbl(m_idx);
            if (md != m_mode) begin
                m_cnt = 0;
            end else if (md == M_STEP) begin
                if (rise && e) m_idx = (m_idx % 6) + 1;
            end else if (md == M_AUTO) begin
                if (rise) m_cnt = 0;
                else if (e) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == DW) begin
                        m_cnt = 0;
                        m_idx = (m_idx % 6) + 1;
                    end
                end
            end
            m_btn  = b;
            m_mode = md;
        end
        x.idx = 3'(m_idx);
        q.push_back(x);
    endtask

    // Monitor: compares one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("light", 32'(light), 32'(e.light));
                check("colour_idx", 32'(colour_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        int guard;
        int md;

        // Reset held, then released in WHITE.
        repeat (3) cyc(0, 0, M_WHITE, 0);
        cyc(1, 0, M_WHITE, 0);
        cyc(1, 0, M_WHITE, 0);

        // STEP with seven button pulses.
        cyc(1, 1, M_STEP, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, M_STEP, 1);
            cyc(1, 1, M_STEP, 0);
        end
        cyc(1, 1, M_STEP, 0);

        // Disabled pulse is discarded; held button advances once.
        cyc(0, 0, M_STEP, 0);
        cyc(1, 0, M_STEP, 0);
        cyc(1, 0, M_STEP, 1);
        cyc(1, 0, M_STEP, 0);
        cyc(1, 1, M_STEP, 0);
        repeat (5) cyc(1, 1, M_STEP, 1);
        cyc(1, 1, M_STEP, 0);
        cyc(1, 1, M_STEP, 0);

        // AUTO for 12 enabled cycles from idx 1.
        cyc(0, 0, M_AUTO, 0);
        cyc(1, 0, M_AUTO, 0);
        repeat (12) cyc(1, 1, M_AUTO, 0);
        cyc(1, 0, M_AUTO, 0);

        // Button on the terminal-count cycle, then enable gap mid-dwell.
        repeat (3) cyc(1, 1, M_AUTO, 0);
        cyc(1, 1, M_AUTO, 1);
        repeat (4) cyc(1, 1, M_AUTO, 0);
        repeat (2) cyc(1, 1, M_AUTO, 0);
        repeat (2) cyc(1, 0, M_AUTO, 0);
        repeat (3) cyc(1, 1, M_AUTO, 0);

        // Run to idx 5, then assert reset between edges.
        guard = 0;
        while (m_idx != 5 && guard < 40) begin
            cyc(1, 1, M_AUTO, 0);
            guard++;
        end
        check("reach_idx5", 32'(m_idx), 32'd5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_light", 32'(light), 32'd0);
        check("async_idx", 32'(colour_idx), 32'd1);
        cyc(0, 1, M_AUTO, 0);
        cyc(1, 1, M_AUTO, 0);
        repeat (6) cyc(1, 1, M_AUTO, 0);

        // Random stimulus with mostly stable modes.
        md = M_AUTO;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) md = int'($urandom_range(3));
            cyc(($urandom_range(99) != 0), ($urandom_range(4) != 0), md,
                ($urandom_range(9) < 3));
        end
        cyc(1, 0, M_OFF, 0);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameter COLOR_W, default 8, bits per colour component; light width = 3*COLOR_W.
REQ-002 Parameter DWELL, default 4, enabled cycles per colour in auto mode; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high permits colour advance and dwell counting; low freezes both.
REQ-006 mode  input  2  00 WHITE, 01 OFF, 10 STEP, 11 AUTO.
REQ-007 button  input  1  level input, synchronous to clk; rising edge is the event.
REQ-008 light  output  3*COLOR_W  registered colour, {R,G,B}, each COLOR_W bits.
REQ-009 colour_idx  output  3  current sequence index, registered.

Function
REQ-010 Sequence table, F = all-ones COLOR_W: idx1 {F,0,0}, 2 {F,F,0}, 3 {0,F,0}, 4 {0,F,F}, 5 {0,0,F}, 6 {F,0,F}; idx 0 and 7 never held.
REQ-011 Advance: idx 6 -> 1 (wrap); otherwise idx+1.
REQ-012 btn_q register holds the previous button sample; rise = button & !btn_q.
REQ-013 STEP: rise with enable=1 advances idx at that edge; rise with enable=0 is discarded, not queued.
REQ-014 AUTO: dwell counter counts 0..DWELL-1 on enabled cycles; at DWELL-1 with enable=1, idx advances and counter returns to 0.
REQ-015 AUTO: rise clears the counter without advancing; rise wins over a simultaneous terminal count.
REQ-016 WHITE and OFF: idx and counter hold; button ignored apart from btn_q tracking.
REQ-017 Any change of mode (mode != registered mode_q) clears the counter that cycle; idx holds.
REQ-018 light <= WHITE: all ones; OFF: 0; STEP/AUTO: table[idx]. Latency: light reflects an idx or mode change one edge later.
REQ-019 DWELL=1: AUTO advances on every enabled cycle.
REQ-020 Counter width = clog2(DWELL), minimum 1 bit; never exceeds DWELL-1.

Reset
REQ-021 While rst=0: light = 0, colour_idx = 1, counter = 0, btn_q = 0, mode_q = OFF, asynchronously.
REQ-022 Release of rst mid-sequence restarts from idx 1 with counter 0; the first sampled button high after release counts as a rise.

Structure
REQ-023 Package light_pkg holds mode encodings (MODE_WHITE, MODE_OFF, MODE_STEP, MODE_AUTO) and the index constants IDX_FIRST=1 and IDX_LAST=6.
REQ-024 Sub-module colour_lut: combinational idx -> {R,G,B}, parametrised by COLOR_W; instantiated once.

Verification (COLOR_W=8, DWELL=4)
REQ-025 rst=0 for 3 cycles, then release with mode=WHITE -> light=0 during reset; light=24'hFFFFFF one edge after release.
REQ-026 STEP with enable=1 and 7 single-cycle button pulses -> colour_idx goes 2,3,4,5,6,1,2; after the 7th, light=24'hFFFF00.
REQ-027 STEP with enable=0, button pulse -> colour_idx stays 1; button held high 5 cycles with enable=1 -> exactly one advance.
REQ-028 AUTO with enable=1 for 12 cycles from idx 1 -> advances after cycles 4, 8, 12; idx=4; light=24'h00FFFF one edge later.
REQ-029 AUTO with button rise on the terminal-count cycle -> no advance; next advance 4 enabled cycles later. Toggle enable low for 2 cycles mid-dwell -> advance delayed by exactly 2 cycles.
REQ-030 rst asserted mid-AUTO at idx 5 -> light=0 immediately without a clock edge; after release in AUTO, idx=1 and first advance after 4 cycles.
